alu_cmd_queue: RTL and testbench

- Command buffer directly upstream of the N-bit ALU. Accepts {oper, a, b} operation commands over a valid/ready handshake and stores them in a DEPTH-entry FIFO.
- Presents the head command combinationally on the ALU operand/opcode inputs, and the consumer pops it with out_ready.
- Rejects divide/modulo-by-zero commands at the input and counts them.

---
 rtl/alu_cmd_queue_if.sv | 26 ++
 rtl/alu_cmd_queue.sv | 86 ++++++++
 tb/tb_alu_cmd_queue.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_queue_if.sv
// Producer/consumer bundle for the ALU command queue.
// The queue is the slave; the producer/ALU side is the master.
interface alu_cmd_queue_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [2:0]   in_oper;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [2:0]   oper;

  modport slave (
    input  in_valid, in_a, in_b, in_oper, out_ready,
    output in_ready, out_valid, a, b, oper
  );

  modport master (
    output in_valid, in_a, in_b, in_oper, out_ready,
    input  in_ready, out_valid, a, b, oper
  );
endinterface

// File: rtl/alu_cmd_queue.sv
// Command FIFO in front of the ALU; drops div/mod-by-zero commands at
// the input, flags them with a one-cycle pulse and counts them.
module alu_cmd_queue #(
  parameter int N     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic            clk,
  input  logic            rst,
  alu_cmd_queue_if.slave  bus,
  output logic [AW:0]     count,
  output logic            div_zero_err,
  output logic [7:0]      rej_count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [N-1:0] a_mem_q  [DEPTH];
  logic [N-1:0] b_mem_q  [DEPTH];
  logic [2:0]   op_mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          err_q, err_d;
  logic [7:0]    rej_q, rej_d;

  logic xfer, reject, push, pop, out_valid;

  assign bus.in_ready = (count_q != FULL_CNT);
  assign out_valid    = (count_q != '0);
  assign bus.out_valid = out_valid;

  assign xfer   = bus.in_valid && bus.in_ready;
  assign reject = xfer && (bus.in_oper == 3'b010 || bus.in_oper == 3'b011)
                  && (bus.in_b == '0);
  assign push   = xfer && !reject;
  assign pop    = out_valid && bus.out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = reject;
    rej_d    = rej_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    if (reject && rej_q != 8'hFF) rej_d = rej_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      rej_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      rej_q    <= rej_d;
    end
  end

  // Data array needs no reset: pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      a_mem_q[wr_ptr_q]  <= bus.in_a;
      b_mem_q[wr_ptr_q]  <= bus.in_b;
      op_mem_q[wr_ptr_q] <= bus.in_oper;
    end
  end

  assign bus.a    = out_valid ? a_mem_q[rd_ptr_q]  : '0;
  assign bus.b    = out_valid ? b_mem_q[rd_ptr_q]  : '0;
  assign bus.oper = out_valid ? op_mem_q[rd_ptr_q] : '0;

  assign count        = count_q;
  assign div_zero_err = err_q;
  assign rej_count    = rej_q;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Scoreboard bench for alu_cmd_queue: accepted commands are queued when
// driven and compared against the head when the bench pops them.
module tb_alu_cmd_queue;
  localparam int N = 8;
  localparam int DEPTH = 4;
  localparam int AW = 2;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  logic        clk;
  logic        rst;
  logic [AW:0] count;
  logic        div_zero_err;
  logic [7:0]  rej_count;

  alu_cmd_queue_if #(.N(N)) bus ();

  alu_cmd_queue #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .count(count), .div_zero_err(div_zero_err), .rej_count(rej_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  cmd_t sb[$];
  int   m_rej = 0;
  bit   popped;
  bit   exp_err;
  cmd_t exp_c, obs_c;

  // Drive one cycle, capture the head before the edge, update the model after it.
  task automatic step(input bit v, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input bit rdy);
    bit acc, rej;
    bus.in_valid = v; bus.in_oper = op; bus.in_a = a; bus.in_b = b;
    bus.out_ready = rdy;
    @(negedge clk);
    popped = (sb.size() != 0) && rdy;
    if (popped) begin
      exp_c = sb[0];
      obs_c = {bus.oper, bus.a, bus.b};
    end
    acc = v && (sb.size() != DEPTH);
    rej = acc && (op == 3'b010 || op == 3'b011) && (b == 8'd0);
    @(posedge clk); #1;
    if (popped) void'(sb.pop_front());
    if (acc && !rej) sb.push_back('{op, a, b});
    if (rej && m_rej < 255) m_rej++;
    exp_err = rej;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_oper = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb.delete(); m_rej = 0;
    checks++;
    if (count !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_flags count=%0d out_valid=%b in_ready=%b want 0/0/1",
               count, bus.out_valid, bus.in_ready);
    end
    checks++;
    if ({bus.oper, bus.a, bus.b} !== 19'd0 || rej_count !== 8'd0 || div_zero_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_data oper=%0d a=%0d b=%0d rej=%0d err=%b want zeros",
               bus.oper, bus.a, bus.b, rej_count, div_zero_err);
    end
  endtask

  task automatic test_drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      step(1'b0, 3'd0, 8'd0, 8'd0, 1'b1);
      guard++;
      checks++;
      if (obs_c !== exp_c) begin
        failures++;
        $display("FAIL drain_pop got=%h want=%h", obs_c, exp_c);
      end
    end
    checks++;
    if (count !== 3'd0 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_empty count=%0d out_valid=%b want 0/0", count, bus.out_valid);
    end
  endtask

  task automatic test_basic();
    step(1'b1, 3'b000, 8'd100, 8'd50, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.a !== 8'd100 || count !== 3'd1) begin
      failures++;
      $display("FAIL basic_latency out_valid=%b a=%0d count=%0d want 1/100/1",
               bus.out_valid, bus.a, count);
    end
    step(1'b1, 3'b001, 8'd4, 8'd5, 1'b0);
    checks++;
    if (count !== 3'd2 || bus.a !== 8'd100 || bus.b !== 8'd50 || bus.oper !== 3'b000) begin
      failures++;
      $display("FAIL basic_head count=%0d a=%0d b=%0d oper=%0d want 2/100/50/0",
               count, bus.a, bus.b, bus.oper);
    end
    step(1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
    checks++;
    if (bus.a !== 8'd100 || bus.oper !== 3'b000) begin
      failures++;
      $display("FAIL basic_stall a=%0d oper=%0d want 100/0", bus.a, bus.oper);
    end
    step(1'b0, 3'd0, 8'd0, 8'd0, 1'b1);
    checks++;
    if (count !== 3'd1 || bus.a !== 8'd4 || bus.b !== 8'd5 || bus.oper !== 3'b001) begin
      failures++;
      $display("FAIL basic_pop count=%0d a=%0d b=%0d oper=%0d want 1/4/5/1",
               count, bus.a, bus.b, bus.oper);
    end
    test_drain();
  endtask

  task automatic test_reject();
    step(1'b1, 3'b010, 8'd5, 8'd0, 1'b0);
    checks++;
    if (div_zero_err !== 1'b1 || rej_count !== 8'd1 || count !== 3'd0 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reject_pulse err=%b rej=%0d count=%0d out_valid=%b want 1/1/0/0",
               div_zero_err, rej_count, count, bus.out_valid);
    end
    step(1'b0, 3'd0, 8'd0, 8'd0, 1'b0);
    checks++;
    if (div_zero_err !== 1'b0) begin
      failures++;
      $display("FAIL reject_one_cycle err=%b want 0", div_zero_err);
    end
    step(1'b1, 3'b011, 8'd5, 8'd3, 1'b0);
    checks++;
    if (bus.a !== 8'd5 || bus.b !== 8'd3 || bus.oper !== 3'b011 || count !== 3'd1) begin
      failures++;
      $display("FAIL reject_mod_ok a=%0d b=%0d oper=%0d count=%0d want 5/3/3/1",
               bus.a, bus.b, bus.oper, count);
    end
    // Reject and pop in the same cycle.
    step(1'b1, 3'b011, 8'd9, 8'd0, 1'b1);
    checks++;
    if (obs_c !== exp_c || div_zero_err !== exp_err || exp_err !== 1'b1 ||
        count !== 3'd0 || int'(rej_count) !== m_rej) begin
      failures++;
      $display("FAIL reject_with_pop pop=%h want=%h err=%b count=%0d rej=%0d want_rej=%0d",
               obs_c, exp_c, div_zero_err, count, rej_count, m_rej);
    end
  endtask

  task automatic test_full();
    step(1'b1, 3'b100, 8'hF4, 8'h01, 1'b0);
    step(1'b1, 3'b101, 8'h0F, 8'h01, 1'b0);
    step(1'b1, 3'b110, 8'hAF, 8'hF0, 1'b0);
    step(1'b1, 3'b111, 8'hF0, 8'h0C, 1'b0);
    checks++;
    if (count !== 3'd4 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_level count=%0d in_ready=%b want 4/0", count, bus.in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'b000, 8'h11, 8'h22, 1'b0);
      checks++;
      if (count !== 3'd4 || bus.oper !== 3'b100) begin
        failures++;
        $display("FAIL full_hold count=%0d oper=%0d want 4/4", count, bus.oper);
      end
    end
    step(1'b1, 3'b000, 8'h11, 8'h22, 1'b1);
    checks++;
    if (obs_c !== exp_c || exp_c.op !== 3'b100 || count !== 3'd3) begin
      failures++;
      $display("FAIL full_pop got=%h want=%h count=%0d want 3", obs_c, exp_c, count);
    end
    step(1'b1, 3'b000, 8'h11, 8'h22, 1'b0);
    checks++;
    if (count !== 3'd4 || sb[3] !== cmd_t'({3'b000, 8'h11, 8'h22})) begin
      failures++;
      $display("FAIL full_accept_held count=%0d want 4", count);
    end
    test_drain();
  endtask

  task automatic test_back_to_back();
    step(1'b1, 3'b110, 8'h01, 8'h02, 1'b0);
    step(1'b1, 3'b111, 8'h03, 8'h04, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 3'(i), 8'(8'h20 + i), 8'(i + 1), 1'b1);
      checks++;
      if (obs_c !== exp_c || count !== 3'd2) begin
        failures++;
        $display("FAIL b2b_pop%0d got=%h want=%h count=%0d want 2", i, obs_c, exp_c, count);
      end
    end
    test_drain();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 260; i++) begin
      step(1'b1, 3'b010, 8'(i), 8'd0, 1'b0);
      checks++;
      if (count !== 3'd0 || int'(rej_count) !== m_rej || div_zero_err !== 1'b1) begin
        failures++;
        $display("FAIL sat_step%0d count=%0d rej=%0d want_rej=%0d err=%b",
                 i, count, rej_count, m_rej, div_zero_err);
      end
    end
    checks++;
    if (rej_count !== 8'd255) begin
      failures++;
      $display("FAIL sat_final rej=%0d want 255", rej_count);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 3'b000, 8'(i + 7), 8'(i + 1), 1'b0);
    checks++;
    if (count !== 3'd3) begin
      failures++;
      $display("FAIL midrst_pre count=%0d want 3", count);
    end
    bus.in_valid = 1'b1; bus.in_oper = 3'b001; bus.in_a = 8'h55; bus.in_b = 8'h66;
    bus.out_ready = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    sb.delete(); m_rej = 0;
    checks++;
    if (count !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        {bus.oper, bus.a, bus.b} !== 19'd0 || rej_count !== 8'd0) begin
      failures++;
      $display("FAIL midrst_state count=%0d out_valid=%b in_ready=%b a=%0d rej=%0d",
               count, bus.out_valid, bus.in_ready, bus.a, rej_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reject();
    test_full();
    test_back_to_back();
    test_saturation();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
